// File: rtl/dispatch_issue_sched.sv
// Dispatch/issue scheduler: pops the fetch queue into ALU/AGU/MUL/DIV reservation queues,
// allocates destination tags and stalls on branches. Optional perf counters: DISPATCH_PERF_CNT_EN.
module dispatch_issue_sched #(
    parameter int unsigned TAG_W = 6,
    parameter int unsigned XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ifq_empty,
    input  logic [XLEN-1:0]  ifq_icode,
    input  logic [XLEN-1:0]  ifq_pc,
    output logic             ifq_rd_en,
    output logic             ifq_flush,
    input  logic             dec_alu_en,
    input  logic             dec_agu_en,
    input  logic             dec_mul_en,
    input  logic             dec_div_en,
    input  logic             dec_reg_w,
    input  logic             dec_jmp,
    input  logic             dec_branch,
    input  logic             alu_q_full,
    input  logic             agu_q_full,
    input  logic             mul_q_full,
    input  logic             div_q_full,
    output logic             alu_q_wr,
    output logic             agu_q_wr,
    output logic             mul_q_wr,
    output logic             div_q_wr,
    output logic [XLEN-1:0]  issue_icode,
    output logic [XLEN-1:0]  issue_pc,
    output logic [TAG_W-1:0] issue_tag,
    input  logic             tag_ret,
    input  logic             br_resolved,
    input  logic             br_redirect,
`ifdef DISPATCH_PERF_CNT_EN
    output logic [31:0]      perf_stall_cnt,
    output logic [15:0]      perf_flush_cnt,
`endif
    output logic             stall
);

    localparam int unsigned NUM_TAGS = 1 << TAG_W;
    localparam logic [TAG_W-1:0] TAG_MAX = TAG_W'(NUM_TAGS - 1);
    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_RES = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [3:0]        r_q_wr;
    logic              r_ifq_flush;
    logic [XLEN-1:0]   r_issue_icode;
    logic [XLEN-1:0]   r_issue_pc;
    logic [TAG_W-1:0]  r_issue_tag;
    logic [TAG_W-1:0]  r_tag_ptr;
    logic [TAG_W-1:0]  r_outstanding;

    logic              w_tgt_full;
    logic              w_any_en;
    logic              w_tags_exhausted;
    logic              w_fire;
    logic              w_alloc;
    logic              w_ret;
    logic              w_enter_flush;

    assign w_tgt_full = (alu_q_full & dec_alu_en) | (agu_q_full & dec_agu_en) |
                        (mul_q_full & dec_mul_en) | (div_q_full & dec_div_en);
    assign w_any_en   = dec_alu_en | dec_agu_en | dec_mul_en | dec_div_en;
    assign w_tags_exhausted = dec_reg_w & (r_outstanding == TAG_MAX);

    // Fire is forced low in reset so nothing is popped while rst_n is held.
    assign w_fire = rst_n & (r_state == RUN) & ~ifq_empty & ~w_tgt_full & ~w_tags_exhausted;
    // Ops with no target queue are popped and dropped without consuming a tag.
    assign w_alloc = w_fire & dec_reg_w & w_any_en;
    assign w_ret   = tag_ret & (r_outstanding != '0);
    assign w_enter_flush = (r_state == WAIT_RES) & br_resolved & br_redirect;

    assign ifq_rd_en = w_fire;
    assign stall     = rst_n & ~ifq_empty & ~w_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_fire && (dec_branch || dec_jmp)) w_state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                if (br_resolved) w_state_nxt = br_redirect ? FLUSH : RUN;
            end
            FLUSH:   w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Registered issue stage: one cycle after fire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q_wr        <= '0;
            r_ifq_flush   <= 1'b0;
            r_issue_icode <= '0;
            r_issue_pc    <= '0;
            r_issue_tag   <= '0;
        end else begin
            r_q_wr      <= w_fire ? {dec_alu_en, dec_agu_en, dec_mul_en, dec_div_en} : 4'b0000;
            r_ifq_flush <= w_enter_flush;
            if (w_fire) begin
                r_issue_icode <= ifq_icode;
                r_issue_pc    <= ifq_pc;
                r_issue_tag   <= (dec_reg_w && w_any_en) ? r_tag_ptr : '0;
            end
        end
    end

    // Tag pointer wraps over 1..NUM_TAGS-1; tag 0 means "no destination".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_ptr     <= TAG_ONE;
            r_outstanding <= '0;
        end else begin
            if (w_alloc) r_tag_ptr <= (r_tag_ptr == TAG_MAX) ? TAG_ONE : r_tag_ptr + TAG_ONE;
            if (w_alloc && !w_ret)      r_outstanding <= r_outstanding + TAG_ONE;
            else if (!w_alloc && w_ret) r_outstanding <= r_outstanding - TAG_ONE;
        end
    end

    assign alu_q_wr    = r_q_wr[3];
    assign agu_q_wr    = r_q_wr[2];
    assign mul_q_wr    = r_q_wr[1];
    assign div_q_wr    = r_q_wr[0];
    assign ifq_flush   = r_ifq_flush;
    assign issue_icode = r_issue_icode;
    assign issue_pc    = r_issue_pc;
    assign issue_tag   = r_issue_tag;

`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != '1))         r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_enter_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_dispatch_issue_sched.sv
// Directed bench for dispatch_issue_sched, built with TAG_W=2 so tag exhaustion is reachable.
module tb_dispatch_issue_sched;

    localparam int unsigned TAG_W = 2;
    localparam int unsigned XLEN  = 32;

    logic             clk;
    logic             rst_n;
    logic             ifq_empty;
    logic [XLEN-1:0]  ifq_icode;
    logic [XLEN-1:0]  ifq_pc;
    logic             ifq_rd_en;
    logic             ifq_flush;
    logic             dec_alu_en, dec_agu_en, dec_mul_en, dec_div_en;
    logic             dec_reg_w, dec_jmp, dec_branch;
    logic             alu_q_full, agu_q_full, mul_q_full, div_q_full;
    logic             alu_q_wr, agu_q_wr, mul_q_wr, div_q_wr;
    logic [XLEN-1:0]  issue_icode;
    logic [XLEN-1:0]  issue_pc;
    logic [TAG_W-1:0] issue_tag;
    logic             tag_ret, br_resolved, br_redirect;
    logic             stall;
`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0]      perf_stall_cnt;
    logic [15:0]      perf_flush_cnt;
`endif

    int n_vec;
    int n_err;
    int exp_stall;

    dispatch_issue_sched #(.TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifq_empty(ifq_empty), .ifq_icode(ifq_icode), .ifq_pc(ifq_pc),
        .ifq_rd_en(ifq_rd_en), .ifq_flush(ifq_flush),
        .dec_alu_en(dec_alu_en), .dec_agu_en(dec_agu_en),
        .dec_mul_en(dec_mul_en), .dec_div_en(dec_div_en),
        .dec_reg_w(dec_reg_w), .dec_jmp(dec_jmp), .dec_branch(dec_branch),
        .alu_q_full(alu_q_full), .agu_q_full(agu_q_full),
        .mul_q_full(mul_q_full), .div_q_full(div_q_full),
        .alu_q_wr(alu_q_wr), .agu_q_wr(agu_q_wr), .mul_q_wr(mul_q_wr), .div_q_wr(div_q_wr),
        .issue_icode(issue_icode), .issue_pc(issue_pc), .issue_tag(issue_tag),
        .tag_ret(tag_ret), .br_resolved(br_resolved), .br_redirect(br_redirect),
`ifdef DISPATCH_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check combinational outputs for the current inputs, then advance one clock.
    task automatic tick(input logic e_rd, input logic e_stall);
        #1;
        chk("ifq_rd_en", 32'(ifq_rd_en), 32'(e_rd));
        chk("stall", 32'(stall), 32'(e_stall));
        if (e_stall) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wr4();
        return 32'({alu_q_wr, agu_q_wr, mul_q_wr, div_q_wr});
    endfunction

    initial begin
        n_vec = 0; n_err = 0; exp_stall = 0;
        rst_n = 1'b0;
        ifq_empty = 1'b0; ifq_icode = 32'hDEAD; ifq_pc = 32'h40;
        dec_alu_en = 1'b1; dec_agu_en = 1'b0; dec_mul_en = 1'b0; dec_div_en = 1'b0;
        dec_reg_w = 1'b1; dec_jmp = 1'b0; dec_branch = 1'b0;
        alu_q_full = 1'b0; agu_q_full = 1'b0; mul_q_full = 1'b0; div_q_full = 1'b0;
        tag_ret = 1'b0; br_resolved = 1'b0; br_redirect = 1'b0;
        @(posedge clk); #1;

        // Reset held with a valid ALU op at the head
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("rst_wr", wr4(), 32'h0);
        chk("rst_tag", 32'(issue_tag), 32'h0);
        chk("rst_icode", issue_icode, 32'h0);
        chk("rst_flush", 32'(ifq_flush), 32'h0);

        // Back-to-back ALU reg-writes: tags 1,2,3
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifq_icode = 32'h100 + 32'(i);
            ifq_pc    = 32'h1000 + 32'(4 * i);
            tick(1'b1, 1'b0);
            chk("b2b_alu_wr", 32'(alu_q_wr), 32'h1);
            chk("b2b_tag", 32'(issue_tag), 32'(i + 1));
            chk("b2b_icode", issue_icode, 32'h100 + 32'(i));
            chk("b2b_pc", issue_pc, 32'h1000 + 32'(4 * i));
        end
        ifq_empty = 1'b1;
        tick(1'b0, 1'b0);
        chk("strobe_single", wr4(), 32'h0);

        // Tag exhaustion: 3 outstanding
        ifq_empty = 1'b0;
        tick(1'b0, 1'b1);
        chk("exh_no_wr", wr4(), 32'h0);
        dec_alu_en = 1'b0; dec_agu_en = 1'b1; dec_reg_w = 1'b0;
        tick(1'b1, 1'b0);
        chk("store_wr", wr4(), 32'h4);
        chk("store_tag", 32'(issue_tag), 32'h0);
        dec_agu_en = 1'b0; dec_alu_en = 1'b1; dec_reg_w = 1'b1; tag_ret = 1'b1;
        tick(1'b0, 1'b1);
        tag_ret = 1'b0;
        tick(1'b1, 1'b0);
        chk("wrap_tag", 32'(issue_tag), 32'h1);
        ifq_empty = 1'b1; tag_ret = 1'b1;
        tick(1'b0, 1'b0);
        ifq_empty = 1'b0;
        tick(1'b1, 1'b0);
        chk("alloc_ret_tag", 32'(issue_tag), 32'h2);
        tag_ret = 1'b0;
        tick(1'b1, 1'b0);
        chk("tag3", 32'(issue_tag), 32'h3);
        tick(1'b0, 1'b1);

        // Drain plus one extra retire (must saturate at 0)
        ifq_empty = 1'b1; tag_ret = 1'b1;
        repeat (4) tick(1'b0, 1'b0);
        tag_ret = 1'b0; ifq_empty = 1'b0;
        tick(1'b1, 1'b0);
        chk("sat_tag", 32'(issue_tag), 32'h1);
        ifq_empty = 1'b1; tag_ret = 1'b1;
        tick(1'b0, 1'b0);
        tag_ret = 1'b0;

        // Backpressure on MUL
        ifq_empty = 1'b0; dec_alu_en = 1'b0; dec_mul_en = 1'b1; dec_reg_w = 1'b0; mul_q_full = 1'b1;
        ifq_icode = 32'h200;
        repeat (4) begin
            tick(1'b0, 1'b1);
            chk("bp_no_wr", wr4(), 32'h0);
        end
        mul_q_full = 1'b0;
        tick(1'b1, 1'b0);
        chk("bp_mul_wr", wr4(), 32'h2);
        dec_mul_en = 1'b0; dec_alu_en = 1'b1; mul_q_full = 1'b1;
        tick(1'b1, 1'b0);
        chk("bp_alu_wr", wr4(), 32'h8);
        mul_q_full = 1'b0;
        dec_alu_en = 1'b0; dec_div_en = 1'b1;
        tick(1'b1, 1'b0);
        chk("div_wr", wr4(), 32'h1);

        // Illegal opcode: popped, dropped, no tag
        dec_div_en = 1'b0; dec_reg_w = 1'b1; ifq_icode = 32'hFFFF_FFFF;
        tick(1'b1, 1'b0);
        chk("ill_wr", wr4(), 32'h0);
        chk("ill_tag", 32'(issue_tag), 32'h0);
        dec_alu_en = 1'b1; ifq_icode = 32'h300;
        tick(1'b1, 1'b0);
        chk("post_ill_tag", 32'(issue_tag), 32'h2);

        // Branch with redirect
        dec_reg_w = 1'b0; dec_branch = 1'b1;
        tick(1'b1, 1'b0);
        chk("br_issue", wr4(), 32'h8);
        dec_branch = 1'b0;
        tick(1'b0, 1'b1);
        chk("wait_no_wr", wr4(), 32'h0);
        tick(1'b0, 1'b1);
        br_resolved = 1'b1; br_redirect = 1'b1;
        tick(1'b0, 1'b1);
        chk("flush_pulse", 32'(ifq_flush), 32'h1);
        br_resolved = 1'b0; br_redirect = 1'b0;
        tick(1'b0, 1'b1);
        chk("flush_one", 32'(ifq_flush), 32'h0);
        tick(1'b1, 1'b0);
        chk("run_after_flush", wr4(), 32'h8);

        // Jump resolved without redirect
        dec_jmp = 1'b1;
        tick(1'b1, 1'b0);
        dec_jmp = 1'b0; ifq_empty = 1'b1; br_resolved = 1'b1;
        tick(1'b0, 1'b0);
        chk("nored_flush", 32'(ifq_flush), 32'h0);
        br_resolved = 1'b0; ifq_empty = 1'b0;
        tick(1'b1, 1'b0);

        // Resolve in RUN is ignored
        br_resolved = 1'b1; br_redirect = 1'b1;
        tick(1'b1, 1'b0);
        chk("run_res_flush", 32'(ifq_flush), 32'h0);
        br_resolved = 1'b0; br_redirect = 1'b0;
        tick(1'b1, 1'b0);
        chk("run_res_flush2", 32'(ifq_flush), 32'h0);

`ifdef DISPATCH_PERF_CNT_EN
        chk("perf_stall", perf_stall_cnt, 32'(exp_stall));
        chk("perf_flush", 32'(perf_flush_cnt), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
